// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with word framing
module universal_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic                       d,
    input  logic [WIDTH-1:0]           load_data,
    output logic [WIDTH-1:0]           q,
    output logic                       so,
    output logic [$clog2(WIDTH):0]     shift_count,
    output logic                       word_valid
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wv_q, wv_d;

    // Next register contents for the selected operation; reserved acts as hold
    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_SHL:   q_d = {q_q[WIDTH-2:0], d};
                MODE_SHR:   q_d = {d, q_q[WIDTH-1:1]};
                MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_LOAD:  q_d = load_data;
                MODE_CLEAR: q_d = RESET_VAL;
                default:    q_d = q_q;
            endcase
        end
    end

    // Frame counter: only serial shifts count; LOAD/CLEAR restart the frame
    always_comb begin
        cnt_d = cnt_q;
        wv_d  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL, MODE_SHR: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        wv_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                MODE_LOAD, MODE_CLEAR: cnt_d = '0;
                default:               cnt_d = cnt_q;
            endcase
        end
    end

    // Serial out is the bit the current mode will push out at the next edge
    always_comb begin
        so = 1'b0;
        case (mode)
            MODE_SHL, MODE_ROL: so = q_q[WIDTH-1];
            MODE_SHR, MODE_ROR: so = q_q[0];
            default:            so = 1'b0;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            cnt_q <= '0;
            wv_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            wv_q  <= wv_d;
        end
    end

    assign q           = q_q;
    assign shift_count = cnt_q;
    assign word_valid  = wv_q;

    logic unused_hold;
    assign unused_hold = (mode == MODE_HOLD);

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
module tb_universal_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          d = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic [W-1:0]  load_data = '0;

    logic [W-1:0]  q0, q1;
    logic          so0, so1;
    logic [CW-1:0] sc0, sc1;
    logic          wv0, wv1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: two registers (reset value 0 and 0xFF), shared frame counter
    int mq0 = 0;
    int mq1 = 255;
    int mcnt = 0;
    bit mwv = 1'b0;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .load_data(load_data), .q(q0), .so(so0), .shift_count(sc0), .word_valid(wv0)
    );

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'hFF)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d),
        .load_data(load_data), .q(q1), .so(so1), .shift_count(sc1), .word_valid(wv1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_next(input int cur, input int rv);
        int r;
        r = cur;
        case (mode)
            3'd1: r = ((cur * 2) + d) % 256;
            3'd2: r = (cur / 2) + (d ? 128 : 0);
            3'd3: r = ((cur * 2) % 256) + (cur / 128);
            3'd4: r = (cur / 2) + ((cur % 2) * 128);
            3'd5: r = int'(load_data);
            3'd6: r = rv;
            default: r = cur;
        endcase
        return r;
    endfunction

    function automatic int model_so(input int cur);
        if (mode == 3'd1 || mode == 3'd3) return (cur / 128) % 2;
        if (mode == 3'd2 || mode == 3'd4) return cur % 2;
        return 0;
    endfunction

    // Behavioural model updated on the same edges as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0 = 0;
            mq1 = 255;
            mcnt = 0;
            mwv = 1'b0;
        end else begin
            mwv = 1'b0;
            if (en) begin
                mq0 = model_next(mq0, 0);
                mq1 = model_next(mq1, 255);
                if (mode == 3'd1 || mode == 3'd2) begin
                    mcnt = (mcnt + 1) % W;
                    mwv = (mcnt == 0);
                end else if (mode == 3'd5 || mode == 3'd6) begin
                    mcnt = 0;
                end
            end
        end
    end

    // Compare every output of both instances against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q0", q0, mq0);
            chk("q1", q1, mq1);
            chk("so0", so0, model_so(mq0));
            chk("so1", so1, model_so(mq1));
            chk("cnt0", sc0, mcnt);
            chk("cnt1", sc1, mcnt);
            chk("wv0", wv0, mwv);
            chk("wv1", wv1, mwv);
        end
    end

    task automatic drive(input logic e, input logic [2:0] m, input logic dd, input logic [W-1:0] ld);
        en = e;
        mode = m;
        d = dd;
        load_data = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bits8;
        logic [4:0] bits5;
        logic [7:0] exp_q8 [8];
        logic [7:0] exp_q5 [5];
        exp_q5 = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16};
        exp_q8 = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h53, 8'hA6};
        bits5 = 5'b01101;
        bits8 = 8'b01100101;

        tick();
        chk_en = 1'b1;
        chk("rst_q0", q0, 8'h00);
        chk("rst_q1", q1, 8'hFF);
        tick();
        rst_n = 1'b1;

        // Serial left shift from zero
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'd1, bits5[i], '0);
            tick();
            chk("shl_q", q0, exp_q5[i]);
            chk("shl_cnt", sc0, i + 1);
            chk("shl_wv", wv0, 0);
        end

        // Full frame after clearing
        drive(1'b1, 3'd6, 1'b0, '0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd1, bits8[i], '0);
            tick();
            chk("frm_q", q0, exp_q8[i]);
        end
        chk("frm_wv", wv0, 1);
        chk("frm_cnt", sc0, 0);
        drive(1'b1, 3'd1, 1'b0, '0);
        tick();
        chk("frm9_wv", wv0, 0);
        chk("frm9_cnt", sc0, 1);
        chk("frm9_q", q0, 8'h4C);

        // Rotate and right shift
        drive(1'b1, 3'd5, 1'b0, 8'h81);
        tick();
        drive(1'b1, 3'd4, 1'b1, '0);
        #1;
        chk("ror_so", so0, 1);
        tick();
        chk("ror_q", q0, 8'hC0);
        drive(1'b1, 3'd3, 1'b0, '0);
        tick();
        chk("rol_q", q0, 8'h81);
        chk("rot_cnt", sc0, 0);
        drive(1'b1, 3'd2, 1'b0, '0);
        tick();
        chk("shr_q", q0, 8'h40);
        chk("shr_cnt", sc0, 1);
        chk("shr_so", so0, 0);

        // Enable hold, then LOAD on the frame-completing edge
        drive(1'b1, 3'd5, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 3'd1, 1'b1, '0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd1, 1'b1, '0);
            tick();
            chk("en_q", q0, 8'h7F);
            chk("en_cnt", sc0, 7);
            chk("en_wv", wv0, 0);
        end
        drive(1'b1, 3'd5, 1'b1, 8'h3C);
        tick();
        chk("ld_q", q0, 8'h3C);
        chk("ld_cnt", sc0, 0);
        chk("ld_wv", wv0, 0);

        // Reserved mode and CLEAR
        drive(1'b1, 3'd7, 1'b1, '0);
        tick();
        chk("rsv_q1", q1, 8'h3C);
        drive(1'b1, 3'd6, 1'b1, '0);
        tick();
        chk("clr_q1", q1, 8'hFF);
        chk("clr_q0", q0, 8'h00);
        chk("clr_cnt", sc1, 0);

        // Back-to-back frames and mixed directions, checked by the model
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 3'd1, 1'($urandom_range(0, 1)), '0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(1, 7)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            tick();
        end

        // Asynchronous reset mid-cycle, mid-frame
        drive(1'b1, 3'd5, 1'b0, 8'hA5);
        tick();
        chk("pre_rst_q", q0, 8'hA5);
        drive(1'b1, 3'd1, 1'b1, '0);
        tick();
        tick();
        drive(1'b0, 3'd0, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q0", q0, 8'h00);
        chk("arst_q1", q1, 8'hFF);
        chk("arst_cnt", sc0, 0);
        chk("arst_wv", wv0, 0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 1'b1, '0);
        tick();
        chk("post_rst_cnt", sc0, 1);
        chk("post_rst_q", q0, 8'h01);
        tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
